// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: mode encoding and FSM states.
package shift_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b101;
  localparam logic [MODE_W-1:0] MODE_CLR  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_core.sv
// Combinational next-value function of the shift register.
// Ports:
//   q      - current register contents
//   mode   - operation select (MODE_* encoding)
//   din    - parallel load data
//   ser_r  - serial bit entering at the MSB on right shift
//   ser_l  - serial bit entering at the LSB on left shift
//   next_c - value the register takes if this operation executes
module shift_core
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]  q,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  din,
  input  logic              ser_r,
  input  logic              ser_l,
  output logic [WIDTH-1:0]  next_c
);

  // Operation decode
  always_comb begin
    next_c = q;
    case (mode)
      MODE_HOLD: next_c = q;
      MODE_SHR:  next_c = {ser_r, q[WIDTH-1:1]};
      MODE_SHL:  next_c = {q[WIDTH-2:0], ser_l};
      MODE_ROR:  next_c = {q[0], q[WIDTH-1:1]};
      MODE_ROL:  next_c = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_LOAD: next_c = din;
      MODE_CLR:  next_c = '0;
      MODE_ASR:  next_c = {q[WIDTH-1], q[WIDTH-1:1]};
      default:   next_c = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with direct (one op per enabled clock) and burst
// (Start/Count runs a latched op N times) operation.
// Ports:
//   clk, Reset      - rising-edge clock, synchronous active-high reset
//   En              - clock enable for register ops and burst progress
//   Mode            - operation select (MODE_* encoding)
//   Din             - parallel load data
//   SerInR, SerInL  - serial inputs for right / left shifts
//   Start, Count    - burst request and number of operations
//   Busy, Done      - burst in progress / one-cycle completion pulse
//   Out             - register contents
//   SerOutR/SerOutL - Out[0] / Out[WIDTH-1]
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              En,
  input  logic [MODE_W-1:0] Mode,
  input  logic [WIDTH-1:0]  Din,
  input  logic              SerInR,
  input  logic              SerInL,
  input  logic              Start,
  input  logic [CNT_W-1:0]  Count,
  output logic              Busy,
  output logic              Done,
  output logic [WIDTH-1:0]  Out,
  output logic              SerOutR,
  output logic              SerOutL
);

  state_t              state_q, state_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                busy_q, busy_d;
  logic                done_d;
  logic                done_q;
  logic [MODE_W-1:0]   core_mode;
  logic [WIDTH-1:0]    core_next;

  // During a burst the latched mode drives the core; otherwise the live Mode.
  assign core_mode = (state_q == ST_RUN) ? mode_q : Mode;

  shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .q      (out_q),
    .mode   (core_mode),
    .din    (Din),
    .ser_r  (SerInR),
    .ser_l  (SerInL),
    .next_c (core_next)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_HOLD;
      remaining_q <= '0;
      out_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state, counter and handshake logic
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    out_d       = out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;  // Done is a pulse; it drops even when En is low
    if (En) begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            if (Count != '0) begin
              mode_d      = Mode;
              remaining_d = Count;
              busy_d      = 1'b1;
              state_d     = ST_RUN;
            end else begin
              done_d = 1'b1;  // empty burst completes immediately
            end
          end else begin
            out_d = core_next;
          end
        end
        ST_RUN: begin
          out_d       = core_next;
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign Out     = out_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign SerOutR = out_q[0];
  assign SerOutL = out_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, CNT_W=4).
module tb_univ_shift_reg;
  import shift_pkg::*;

  logic              clk;
  logic              Reset;
  logic              En;
  logic [MODE_W-1:0] Mode;
  logic [7:0]        Din;
  logic              SerInR;
  logic              SerInL;
  logic              Start;
  logic [3:0]        Count;
  logic              Busy;
  logic              Done;
  logic [7:0]        Out;
  logic              SerOutR;
  logic              SerOutL;

  int checks_total;
  int checks_passed;

  univ_shift_reg #(
    .WIDTH (8),
    .CNT_W (4)
  ) dut (
    .clk     (clk),
    .Reset   (Reset),
    .En      (En),
    .Mode    (Mode),
    .Din     (Din),
    .SerInR  (SerInR),
    .SerInL  (SerInL),
    .Start   (Start),
    .Count   (Count),
    .Busy    (Busy),
    .Done    (Done),
    .Out     (Out),
    .SerOutR (SerOutR),
    .SerOutL (SerOutL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hs(input string tag, input logic [7:0] o, input logic b, input logic d);
    check({tag, ".out"}, 32'(Out), 32'(o));
    check({tag, ".busy"}, 32'(Busy), 32'(b));
    check({tag, ".done"}, 32'(Done), 32'(d));
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    Reset = 1'b1; En = 1'b0; Mode = MODE_HOLD; Din = 8'h00;
    SerInR = 1'b0; SerInL = 1'b0; Start = 1'b0; Count = 4'd0;
    #2;
    tick(); tick();
    Reset = 1'b0;
    chk_hs("reset", 8'h00, 1'b0, 1'b0);

    // Direct operations
    En = 1'b1; Mode = MODE_LOAD; Din = 8'hA5; tick();
    check("load_a5", 32'(Out), 32'h0000_00A5);
    check("serout_r_a5", 32'(SerOutR), 32'd1);
    Mode = MODE_SHR; SerInR = 1'b1; tick();
    check("shr_d2", 32'(Out), 32'h0000_00D2);
    Mode = MODE_LOAD; Din = 8'h80; tick();
    Mode = MODE_ASR; tick();
    check("asr_c0", 32'(Out), 32'h0000_00C0);

    Mode = MODE_LOAD; Din = 8'h81; tick();
    Mode = MODE_ROL; tick();
    check("rol1_03", 32'(Out), 32'h0000_0003);
    for (int i = 0; i < 7; i++) tick();
    check("rol8_81", 32'(Out), 32'h0000_0081);
    Mode = MODE_ROR; tick();
    check("ror_c0", 32'(Out), 32'h0000_00C0);

    Mode = MODE_LOAD; Din = 8'hFF; tick();
    Mode = MODE_SHL; SerInL = 1'b0; tick();
    check("shl_fe", 32'(Out), 32'h0000_00FE);
    check("serout_l_fe", 32'(SerOutL), 32'd1);
    check("serout_r_fe", 32'(SerOutR), 32'd0);

    En = 1'b0; Mode = MODE_CLR; tick();
    check("en0_hold", 32'(Out), 32'h0000_00FE);

    // Burst SHR x3 from 0; Mode changed to CLR mid-burst
    En = 1'b1; Mode = MODE_LOAD; Din = 8'h00; tick();
    Mode = MODE_SHR; SerInR = 1'b1; Start = 1'b1; Count = 4'd3; tick();
    chk_hs("b1_start", 8'h00, 1'b1, 1'b0);
    Start = 1'b0; Mode = MODE_CLR; tick();
    chk_hs("b1_op1", 8'h80, 1'b1, 1'b0);
    tick();
    chk_hs("b1_op2", 8'hC0, 1'b1, 1'b0);
    tick();
    chk_hs("b1_op3", 8'hE0, 1'b0, 1'b1);
    Mode = MODE_HOLD; tick();
    chk_hs("b1_after", 8'hE0, 1'b0, 1'b0);

    // Burst ROL x3 with En toggling 1,0,1,0,1
    Mode = MODE_LOAD; Din = 8'h01; tick();
    Mode = MODE_ROL; Start = 1'b1; Count = 4'd3; tick();
    chk_hs("b2_start", 8'h01, 1'b1, 1'b0);
    Start = 1'b0;
    En = 1'b1; tick(); chk_hs("b2_e1", 8'h02, 1'b1, 1'b0);
    En = 1'b0; tick(); chk_hs("b2_e0a", 8'h02, 1'b1, 1'b0);
    En = 1'b1; tick(); chk_hs("b2_e1b", 8'h04, 1'b1, 1'b0);
    En = 1'b0; tick(); chk_hs("b2_e0b", 8'h04, 1'b1, 1'b0);
    En = 1'b1; tick(); chk_hs("b2_e1c", 8'h08, 1'b0, 1'b1);
    Mode = MODE_HOLD; tick();
    chk_hs("b2_after", 8'h08, 1'b0, 1'b0);

    // Count=0: Done pulse only; Done drops even with En low
    Mode = MODE_CLR; Start = 1'b1; Count = 4'd0; tick();
    chk_hs("c0_done", 8'h08, 1'b0, 1'b1);
    En = 1'b0; Start = 1'b0; tick();
    chk_hs("c0_en0", 8'h08, 1'b0, 1'b0);

    // Back-to-back: second Start issued in the Done cycle
    En = 1'b1; Mode = MODE_HOLD; Start = 1'b1; Count = 4'd0; tick();
    chk_hs("bb_done", 8'h08, 1'b0, 1'b1);
    Mode = MODE_SHL; SerInL = 1'b1; Count = 4'd2; tick();
    chk_hs("bb_start", 8'h08, 1'b1, 1'b0);
    Start = 1'b0; tick();
    chk_hs("bb_op1", 8'h11, 1'b1, 1'b0);
    tick();
    chk_hs("bb_op2", 8'h23, 1'b0, 1'b1);
    Mode = MODE_HOLD; tick();

    // Reset during the 2nd op of a Count=5 burst
    Mode = MODE_ROR; Start = 1'b1; Count = 4'd5; tick();
    Start = 1'b0; tick();
    chk_hs("rb_op1", 8'h91, 1'b1, 1'b0);
    Reset = 1'b1; tick();
    chk_hs("rb_reset", 8'h00, 1'b0, 1'b0);
    Reset = 1'b0; Mode = MODE_HOLD; tick();
    chk_hs("rb_quiet", 8'h00, 1'b0, 1'b0);
    Mode = MODE_LOAD; Din = 8'h3C; tick();
    chk_hs("rb_direct", 8'h3C, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register: hold, logical/arithmetic shift, rotate, parallel load and clear over WIDTH bits.
- Two ways to drive it:
  - Direct mode: one operation per enabled clock.
  - Burst mode: Start/Count command runs a latched operation N times, with Busy/Done handshake.
- Used as the general serialiser/deserialiser and bit-manipulation register in lab designs.

Parameters:
- WIDTH, 8, register width in bits (min 2).
- CNT_W, 4, width of burst Count; max burst = 2^CNT_W-1 operations.

Ports:
- clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- En  in  1  clock enable; gates every register operation and burst progress.
- Mode  in  3  operation select (encoding below).
- Din  in  WIDTH  parallel load data.
- SerInR  in  1  serial input, enters at MSB on right shift.
- SerInL  in  1  serial input, enters at LSB on left shift.
- Start  in  1  burst request (level sampled when En=1).
- Count  in  CNT_W  number of burst operations.
- Busy  out  1  burst in progress.
- Done  out  1  one-cycle pulse after the final burst operation.
- Out  out  WIDTH  register contents.
- SerOutR  out  1  Out[0] (bit leaving on right shift).
- SerOutL  out  1  Out[WIDTH-1] (bit leaving on left shift).

Behaviour:
- Reset, synchronous and highest priority: Out=0, Busy=0, Done=0, state IDLE. A burst in progress is aborted with no Done pulse.
- Mode encoding, with Q = Out:
  - 000 hold.
  - 001 SHR: Q <= {SerInR, Q[W-1:1]}.
  - 010 SHL: Q <= {Q[W-2:0], SerInL}.
  - 011 ROR: Q <= {Q[0], Q[W-1:1]}.
  - 100 ROL: Q <= {Q[W-2:0], Q[W-1]}.
  - 101 LOAD: Q <= Din.
  - 110 CLR: Q <= 0.
  - 111 ASR: Q <= {Q[W-1], Q[W-1:1]}.
- En=0: Out, FSM state and counter all hold. Done still deasserts after its one cycle.
- FSM states: IDLE, RUN.
- IDLE, En=1, Start=0:
  - Direct mode: the Mode operation executes at this edge.
- IDLE, En=1, Start=1, Count>0:
  - Latch Mode into mode_q and Count into remaining.
  - No register operation at this edge.
  - Busy=1 from the next cycle. Go to RUN.
- IDLE, En=1, Start=1, Count=0:
  - No operation, stay IDLE.
  - Done=1 for exactly the next cycle.
- RUN, each edge with En=1:
  - Execute mode_q and decrement remaining.
  - LOAD re-samples Din on each operation.
  - Serial inputs are sampled on each operation.
- RUN, edge where remaining==1:
  - Perform the last operation, go to IDLE.
  - Busy=0 and Done=1 in the following cycle.
- RUN: Start and Mode are ignored; changing Mode mid-burst has no effect.
- Done is a single-cycle pulse. A Start arriving in the Done cycle is accepted normally (back-to-back bursts).
- Latency:
  - Direct op: result visible 1 cycle after the edge.
  - Burst of N with En held high: Busy high for N cycles, Done in cycle N+1 after the Start edge.
- SerOutR and SerOutL are combinational from Out, so they are registered-stable.

Decomposition:
- Shared package (shift_pkg):
  - Mode encoding constants: MODE_HOLD, MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_LOAD, MODE_CLR, MODE_ASR.
  - FSM state constants ST_IDLE, ST_RUN.
- Sub-module shift_core: combinational next-value function of (Q, mode, Din, SerInR, SerInL), instantiated once.
- The top level holds the register, FSM, counter and handshake.

Test Plan:
- Reset then direct LOAD Din=8'hA5 -> Out=8'hA5. Direct SHR with SerInR=1 -> Out=8'hD2, SerOutR was 1 before the edge. ASR from 8'h80 -> 8'hC0.
- Direct ROL x8 starting from 8'h81 -> Out=8'h81 after 8 ops. ROR x1 -> 8'hC0. SHL with SerInL=0 from 8'hFF -> 8'hFE.
- Burst Start, Count=3, Mode=SHR, SerInR=1, from Out=0:
  - Busy high exactly 3 cycles, Out=8'hE0, Done one cycle, then Busy=0.
  - Mode changed to CLR mid-burst has no effect.
- Burst with En toggled 1,0,1,0,1 (Count=3, ROL, Out=8'h01) -> Out=8'h08, Busy spans 5 cycles, a single Done.
- Start with Count=0 -> no Busy, Done pulse next cycle, Out unchanged. Back-to-back Start asserted in the Done cycle -> second burst accepted.
- Reset asserted during the 2nd op of a Count=5 burst -> Out=0, Busy=0, no Done. A subsequent direct op works normally.
